// File: rtl/rover_motion_pkg.sv
// Shared motion codes, FSM state type and code-classification helpers
// for the rover H-bridge path.
package rover_motion_pkg;

  localparam logic [3:0] INERTIAL_STOP = 4'b0000;
  localparam logic [3:0] HARD_STOP     = 4'b1111;
  localparam logic [3:0] FORWARD       = 4'b1001;
  localparam logic [3:0] REVERSE       = 4'b0110;
  localparam logic [3:0] TURN_RIGHT    = 4'b0101;
  localparam logic [3:0] TURN_LEFT     = 4'b1010;

  typedef enum logic {RUN, DEAD} state_t;

  // Bit 1 flags motor A ([3:2]), bit 0 flags motor B ([1:0]).
  function automatic logic [1:0] is_reversal(input logic [3:0] applied,
                                             input logic [3:0] requested);
    logic [1:0] rev;
    rev = 2'b00;
    for (int p = 0; p < 2; p++) begin
      rev[p] = (applied[2*p +: 2] == 2'b10 && requested[2*p +: 2] == 2'b01) ||
               (applied[2*p +: 2] == 2'b01 && requested[2*p +: 2] == 2'b10);
    end
    return rev;
  endfunction

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      INERTIAL_STOP, HARD_STOP, FORWARD, REVERSE, TURN_RIGHT, TURN_LEFT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hbridge_driver_pwm_gen.sv
// Free-running PWM counter with one duty comparator per motor.
module pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [PWM_W-1:0] duty_a,
  input  logic [PWM_W-1:0] duty_b,
  output logic             pwm_a,
  output logic             pwm_b
);

  logic [PWM_W-1:0] cnt;

  // Natural wrap from all-ones back to zero sets the period to 2**PWM_W.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt + 1'b1;
  end

  assign pwm_a = (cnt < duty_a);
  assign pwm_b = (cnt < duty_b);

endmodule

// File: rtl/hbridge_driver.sv
// L298-style bridge driver: dead-time coast on motor reversal plus
// PWM-modulated enables; all outputs registered.
module hbridge_driver
  import rover_motion_pkg::*;
#(
  parameter int DEAD_CYCLES = 50_000,
  parameter int PWM_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       motion_code,
  input  logic [1:0]       enables_in,
  input  logic [PWM_W-1:0] duty_a,
  input  logic [PWM_W-1:0] duty_b,
  output logic [3:0]       h_bridge_ins,
  output logic [1:0]       enables_out,
  output logic [3:0]       previous_motion,
  output logic             in_deadtime
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

  state_t        state, state_next;
  logic [3:0]    pending, pending_next;
  logic [DW-1:0] dead_cnt, dead_cnt_next;
  logic [3:0]    ins_next, applied_next;
  logic          deadtime_next;
  logic [1:0]    en_next;
  logic          legal;
  logic          pwm_a, pwm_b;

  pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clock   (clock),
    .reset_n (reset_n),
    .duty_a  (duty_a),
    .duty_b  (duty_b),
    .pwm_a   (pwm_a),
    .pwm_b   (pwm_b)
  );

  // Brake is never modulated; coast (including dead-time) always disables.
  function automatic logic pair_enable(input logic [1:0] pair, input logic req,
                                       input logic pwm);
    case (pair)
      2'b10, 2'b01: return req & pwm;
      2'b11:        return req;
      default:      return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RUN;
      pending         <= INERTIAL_STOP;
      dead_cnt        <= '0;
      h_bridge_ins    <= INERTIAL_STOP;
      previous_motion <= INERTIAL_STOP;
      in_deadtime     <= 1'b0;
      enables_out     <= 2'b00;
    end else begin
      state           <= state_next;
      pending         <= pending_next;
      dead_cnt        <= dead_cnt_next;
      h_bridge_ins    <= ins_next;
      previous_motion <= applied_next;
      in_deadtime     <= deadtime_next;
      enables_out     <= en_next;
    end
  end

  always_comb begin
    state_next    = state;
    pending_next  = pending;
    dead_cnt_next = dead_cnt;
    ins_next      = h_bridge_ins;
    applied_next  = previous_motion;
    deadtime_next = in_deadtime;
    legal         = is_legal(motion_code);

    case (state)
      RUN: begin
        if (legal) begin
          if (|is_reversal(previous_motion, motion_code)) begin
            pending_next  = motion_code;
            state_next    = DEAD;
            ins_next      = INERTIAL_STOP;
            deadtime_next = 1'b1;
            dead_cnt_next = '0;
          end else begin
            ins_next     = motion_code;
            applied_next = motion_code;
          end
        end
      end
      DEAD: begin
        // Overwriting pending does not restart the count: the bridge is already off.
        dead_cnt_next = dead_cnt + 1'b1;
        if (legal) pending_next = motion_code;
        if (legal && motion_code == HARD_STOP) begin
          state_next    = RUN;
          ins_next      = HARD_STOP;
          applied_next  = HARD_STOP;
          deadtime_next = 1'b0;
          dead_cnt_next = '0;
        end else if (dead_cnt == DEAD_LAST) begin
          state_next    = RUN;
          ins_next      = pending_next;
          applied_next  = pending_next;
          deadtime_next = 1'b0;
          dead_cnt_next = '0;
        end
      end
      default: state_next = RUN;
    endcase

    en_next = {pair_enable(ins_next[3:2], enables_in[1], pwm_a),
               pair_enable(ins_next[1:0], enables_in[0], pwm_b)};
  end

endmodule

// File: tb/tb_hbridge_driver.sv
// Directed, table-driven bench for hbridge_driver with DEAD_CYCLES=8, PWM_W=4.
module tb_hbridge_driver;

  localparam int DEAD_CYCLES = 8;
  localparam int PWM_W       = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       motion_code = 4'b0000;
  logic [1:0]       enables_in = 2'b00;
  logic [PWM_W-1:0] duty_a = '0;
  logic [PWM_W-1:0] duty_b = '0;
  logic [3:0]       h_bridge_ins;
  logic [1:0]       enables_out;
  logic [3:0]       previous_motion;
  logic             in_deadtime;

  int checks = 0;
  int errors = 0;

  hbridge_driver #(.DEAD_CYCLES(DEAD_CYCLES), .PWM_W(PWM_W)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .motion_code     (motion_code),
    .enables_in      (enables_in),
    .duty_a          (duty_a),
    .duty_b          (duty_b),
    .h_bridge_ins    (h_bridge_ins),
    .enables_out     (enables_out),
    .previous_motion (previous_motion),
    .in_deadtime     (in_deadtime)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] code;
    logic [1:0] en;
    logic [3:0] da;
    logic [3:0] db;
    logic [3:0] exp_ins;
    logic [1:0] exp_en;
    logic [3:0] exp_prev;
    logic       exp_dt;
  } vec_t;

  vec_t vecs[10];

  task automatic apply_stimulus(input logic [3:0] code, input logic [1:0] en,
                                input logic [3:0] da, input logic [3:0] db);
    motion_code = code;
    enables_in  = en;
    duty_a      = da;
    duty_b      = db;
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] ins, input logic [1:0] en,
                           input logic [3:0] prev, input logic dt);
    check_output({name, "_ins"},  8'(h_bridge_ins),    8'(ins));
    check_output({name, "_en"},   8'(enables_out),     8'(en));
    check_output({name, "_prev"}, 8'(previous_motion), 8'(prev));
    check_output({name, "_dt"},   8'(in_deadtime),     8'(dt));
  endtask

  // Counts high samples on each enable over one full PWM period.
  task automatic count_period(input logic [3:0] code, input logic [1:0] en,
                              input logic [3:0] da, input logic [3:0] db,
                              output int hi_a, output int hi_b);
    hi_a = 0;
    hi_b = 0;
    for (int k = 0; k < (1 << PWM_W); k++) begin
      apply_stimulus(code, en, da, db);
      if (enables_out[1]) hi_a++;
      if (enables_out[0]) hi_b++;
    end
  endtask

  initial begin
    int n;
    int hi_a, hi_b;
    logic off_ok;

    vecs[0] = '{4'b1001, 2'b11, 4'd0, 4'd0, 4'b1001, 2'b00, 4'b1001, 1'b0};
    vecs[1] = '{4'b1111, 2'b10, 4'd0, 4'd0, 4'b1111, 2'b10, 4'b1111, 1'b0};
    vecs[2] = '{4'b0110, 2'b11, 4'd0, 4'd0, 4'b0110, 2'b00, 4'b0110, 1'b0};
    vecs[3] = '{4'b1011, 2'b11, 4'd0, 4'd0, 4'b0110, 2'b00, 4'b0110, 1'b0};
    vecs[4] = '{4'b0101, 2'b11, 4'd0, 4'd0, 4'b0000, 2'b00, 4'b0110, 1'b1};
    vecs[5] = '{4'b1111, 2'b01, 4'd0, 4'd0, 4'b1111, 2'b01, 4'b1111, 1'b0};
    vecs[6] = '{4'b0000, 2'b11, 4'd0, 4'd0, 4'b0000, 2'b00, 4'b0000, 1'b0};
    vecs[7] = '{4'b1010, 2'b11, 4'd0, 4'd0, 4'b1010, 2'b00, 4'b1010, 1'b0};
    vecs[8] = '{4'b0011, 2'b11, 4'd0, 4'd0, 4'b1010, 2'b00, 4'b1010, 1'b0};
    vecs[9] = '{4'b0101, 2'b11, 4'd0, 4'd0, 4'b0000, 2'b00, 4'b1010, 1'b1};

    // Reset state, then first transaction latency
    @(posedge clock); @(posedge clock); #1;
    check_all("reset", 4'b0000, 2'b00, 4'b0000, 1'b0);
    reset_n = 1'b1;
    apply_stimulus(4'b1001, 2'b11, 4'd8, 4'd8);
    check_output("fwd_after_reset_ins", 8'(h_bridge_ins), 8'h09);
    check_output("fwd_after_reset_prev", 8'(previous_motion), 8'h09);
    for (int k = 0; k < 5; k++) apply_stimulus(4'b1001, 2'b11, 4'd15, 4'd15);
    #2 reset_n = 1'b0;
    #1 check_all("async_reset", 4'b0000, 2'b00, 4'b0000, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].code, vecs[i].en, vecs[i].da, vecs[i].db);
      check_all($sformatf("vec%0d", i), vecs[i].exp_ins, vecs[i].exp_en,
                vecs[i].exp_prev, vecs[i].exp_dt);
    end
    for (int k = 0; k < DEAD_CYCLES; k++) apply_stimulus(4'b0101, 2'b11, 4'd0, 4'd0);
    check_output("vec_tail_ins", 8'(h_bridge_ins), 8'h05);

    // Reversal: FORWARD -> REVERSE holds exactly DEAD_CYCLES coast clocks
    apply_stimulus(4'b0000, 2'b11, 4'd15, 4'd15);
    apply_stimulus(4'b1001, 2'b11, 4'd15, 4'd15);
    check_output("rev_fwd_ins", 8'(h_bridge_ins), 8'h09);
    apply_stimulus(4'b0110, 2'b11, 4'd15, 4'd15);
    check_all("rev_enter", 4'b0000, 2'b00, 4'b1001, 1'b1);
    n = 1;
    off_ok = 1'b1;
    while (in_deadtime && n < 20) begin
      apply_stimulus(4'b0110, 2'b11, 4'd15, 4'd15);
      if (in_deadtime) begin
        n++;
        if (h_bridge_ins != 4'b0000 || enables_out != 2'b00) off_ok = 1'b0;
      end
    end
    check_output("rev_dead_len", 8'(n), 8'(DEAD_CYCLES));
    check_output("rev_dead_off", 8'(off_ok), 8'h01);
    check_output("rev_done_ins", 8'(h_bridge_ins), 8'h06);
    check_output("rev_done_prev", 8'(previous_motion), 8'h06);

    // FORWARD -> TURN_LEFT reverses pair B; HARD_STOP transitions bypass dead-time
    apply_stimulus(4'b0000, 2'b11, 4'd15, 4'd15);
    apply_stimulus(4'b1001, 2'b11, 4'd15, 4'd15);
    apply_stimulus(4'b1010, 2'b11, 4'd15, 4'd15);
    check_output("fwd_left_dt", 8'(in_deadtime), 8'h01);
    for (int k = 0; k < DEAD_CYCLES; k++) apply_stimulus(4'b1010, 2'b11, 4'd15, 4'd15);
    check_output("fwd_left_ins", 8'(h_bridge_ins), 8'h0a);
    apply_stimulus(4'b0000, 2'b11, 4'd15, 4'd15);
    apply_stimulus(4'b1001, 2'b11, 4'd15, 4'd15);
    apply_stimulus(4'b1111, 2'b11, 4'd15, 4'd15);
    check_all("fwd_hard", 4'b1111, 2'b11, 4'b1111, 1'b0);
    apply_stimulus(4'b0110, 2'b11, 4'd0, 4'd0);
    check_all("hard_rev", 4'b0110, 2'b00, 4'b0110, 1'b0);

    // Pending overwritten mid-dead-time: counter keeps running
    apply_stimulus(4'b1001, 2'b11, 4'd15, 4'd15);
    check_output("dead_ovr_enter", 8'(in_deadtime), 8'h01);
    for (int k = 1; k <= DEAD_CYCLES; k++) begin
      apply_stimulus((k < 3) ? 4'b1001 : (k < 5) ? 4'b0110 : 4'b0101, 2'b11, 4'd15, 4'd15);
      if (k == DEAD_CYCLES - 1) check_output("dead_ovr_dt7", 8'(in_deadtime), 8'h01);
    end
    check_all("dead_ovr_done", 4'b0101, 2'b11, 4'b0101, 1'b0);

    // HARD_STOP aborts dead-time at clock 4
    apply_stimulus(4'b1010, 2'b11, 4'd15, 4'd15);
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus((k < 4) ? 4'b1010 : 4'b1111, 2'b11, 4'd15, 4'd15);
      if (k == 3) check_output("dead_abort_dt3", 8'(in_deadtime), 8'h01);
    end
    check_all("dead_abort", 4'b1111, 2'b11, 4'b1111, 1'b0);

    // INERTIAL_STOP during dead-time lets it run out, then coasts
    apply_stimulus(4'b0000, 2'b11, 4'd15, 4'd15);
    apply_stimulus(4'b1001, 2'b11, 4'd15, 4'd15);
    apply_stimulus(4'b0110, 2'b11, 4'd15, 4'd15);
    for (int k = 1; k <= DEAD_CYCLES; k++) begin
      apply_stimulus((k == 1) ? 4'b0000 : 4'b1011, 2'b11, 4'd15, 4'd15);
      if (k == DEAD_CYCLES - 1) check_output("dead_coast_dt7", 8'(in_deadtime), 8'h01);
    end
    check_all("dead_coast", 4'b0000, 2'b00, 4'b0000, 1'b0);

    // PWM duty ratios
    apply_stimulus(4'b1001, 2'b11, 4'd4, 4'd12);
    count_period(4'b1001, 2'b11, 4'd4, 4'd12, hi_a, hi_b);
    check_output("pwm_a_4", 8'(hi_a), 8'd4);
    check_output("pwm_b_12", 8'(hi_b), 8'd12);
    apply_stimulus(4'b1001, 2'b11, 4'd0, 4'd15);
    count_period(4'b1001, 2'b11, 4'd0, 4'd15, hi_a, hi_b);
    check_output("pwm_a_0", 8'(hi_a), 8'd0);
    check_output("pwm_b_15", 8'(hi_b), 8'd15);
    apply_stimulus(4'b1001, 2'b10, 4'd15, 4'd15);
    count_period(4'b1001, 2'b10, 4'd15, 4'd15, hi_a, hi_b);
    check_output("pwm_en_gate_b", 8'(hi_b), 8'd0);
    apply_stimulus(4'b1111, 2'b11, 4'd0, 4'd0);
    count_period(4'b1111, 2'b11, 4'd0, 4'd0, hi_a, hi_b);
    check_output("brake_a", 8'(hi_a), 8'd16);
    check_output("brake_b", 8'(hi_b), 8'd16);

    // Illegal code while FORWARD holds everything
    apply_stimulus(4'b0000, 2'b11, 4'd15, 4'd15);
    apply_stimulus(4'b1001, 2'b11, 4'd15, 4'd15);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(4'b1011, 2'b11, 4'd15, 4'd15);
      check_output($sformatf("illegal%0d_ins", k), 8'(h_bridge_ins), 8'h09);
      check_output($sformatf("illegal%0d_prev", k), 8'(previous_motion), 8'h09);
      check_output($sformatf("illegal%0d_dt", k), 8'(in_deadtime), 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
